// File: rtl/bus_region_decoder.sv
// Registered CPU address-window decoder with one banked window and a one-hot memory request.
// Optional REQ watchdog and ERR state are built when REGION_TIMEOUT_EN is defined.
module bus_region_decoder #(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned NUM_REGIONS    = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {20'hD0000, 20'hA0000, 20'hE0000, 20'h80000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {4{20'hF0000}},
    parameter int unsigned BANK_REGION    = 0,
    parameter int unsigned BANK_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic                   cpu_we,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic                   busy,
    input  logic                   bank_wr,
    input  logic [BANK_W-1:0]      bank_din,
    input  logic [BANK_W-1:0]      bank_mask,
    output logic [NUM_REGIONS:0]   region_req,
    input  logic [NUM_REGIONS:0]   region_ack,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   out_we
);

`ifdef REGION_TIMEOUT_EN
    typedef enum logic [2:0] {StIdle, StDecode, StReq, StDone, StErr} state_e;

    localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign cpu_err = err_q;
`else
    typedef enum logic [1:0] {StIdle, StDecode, StReq, StDone} state_e;

    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign cpu_err        = 1'b0;
`endif

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BANK_W-1:0]   bank_q;
    logic [NUM_REGIONS:0] sel;
    logic                hit;
    logic [BANK_W-1:0]   bank_top;
    logic [ADDR_W-1:0]   xlat_addr;

    // Lowest-index matching window wins; no match selects the default (ROM) slot.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!hit && ((addr_q & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                         (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
                hit    = 1'b1;
                sel[i] = 1'b1;
            end
        end
        if (!hit) begin
            sel[NUM_REGIONS] = 1'b1;
        end
    end

    always_comb begin
        bank_top = (bank_q & bank_mask) | (addr_q[ADDR_W-1 -: BANK_W] & ~bank_mask);
        if (sel[BANK_REGION]) begin
            xlat_addr = {bank_top, addr_q[ADDR_W-BANK_W-1:0]};
        end else if (hit) begin
            xlat_addr = addr_q;
        end else begin
            xlat_addr = {1'b0, addr_q[ADDR_W-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            bank_q     <= '0;
            cpu_ready  <= 1'b0;
            busy       <= 1'b0;
            region_req <= '0;
            out_addr   <= '0;
            out_we     <= 1'b0;
`ifdef REGION_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
`ifdef REGION_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            if (bank_wr) begin
                bank_q <= bank_din;
            end
            unique case (state_q)
                StIdle: begin
                    // The ready cycle still belongs to the finished access.
                    if (cpu_req && !cpu_ready) begin
                        addr_q  <= cpu_addr;
                        out_we  <= cpu_we;
                        busy    <= 1'b1;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    region_req <= sel;
                    out_addr   <= xlat_addr;
                    state_q    <= StReq;
`ifdef REGION_TIMEOUT_EN
                    cnt_q      <= '0;
`endif
                end
                StReq: begin
                    if (|(region_ack & region_req)) begin
                        region_req <= '0;
                        state_q    <= StDone;
                    end
`ifdef REGION_TIMEOUT_EN
                    else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        region_req <= '0;
                        state_q    <= StErr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StDone: begin
                    cpu_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
`ifdef REGION_TIMEOUT_EN
                StErr: begin
                    cpu_ready <= 1'b1;
                    err_q     <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder; entries 1 and 2 overlap at 0xA0000 to exercise priority.
// Cycle k is the cycle after edge k; a strobe driven in cycle 0 is accepted at edge 1.
module tb_bus_region_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_ready;
    logic        cpu_err;
    logic        busy;
    logic        bank_wr;
    logic [3:0]  bank_din;
    logic [3:0]  bank_mask;
    logic [4:0]  region_req;
    logic [4:0]  region_ack;
    logic [19:0] out_addr;
    logic        out_we;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_region_decoder #(
        .ADDR_W        (20),
        .NUM_REGIONS   (4),
        .REGION_BASE   ({20'hD0000, 20'hA0000, 20'hA0000, 20'h80000}),
        .REGION_MASK   ({20'hF0000, 20'hE0000, 20'hF0000, 20'hF0000}),
        .BANK_REGION   (0),
        .BANK_W        (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .bank_wr   (bank_wr),
        .bank_din  (bank_din),
        .bank_mask (bank_mask),
        .region_req(region_req),
        .region_ack(region_ack),
        .out_addr  (out_addr),
        .out_we    (out_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access from strobe to ready; ends in the cycle after cpu_ready (idle, may strobe again).
    task automatic access(input logic [19:0] addr, input logic we, input int wait_n,
                          input logic [4:0] exp_req, input logic [19:0] exp_addr,
                          input string tag, input int strobe_bank = -1,
                          input int req_bank = -1, input bit drop = 1'b0);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cpu_we   = we;
        if (strobe_bank >= 0) begin
            bank_wr  = 1'b1;
            bank_din = 4'(strobe_bank);
        end
        step();  // cycle 1: DECODE
        cpu_req = 1'b0;
        bank_wr = 1'b0;
        check({tag, "/busy_dec"}, 32'(busy), 32'd1);
        check({tag, "/req_dec"}, 32'(region_req), 32'd0);
        step();  // cycle 2: REQ
        check({tag, "/req"}, 32'(region_req), 32'(exp_req));
        check({tag, "/addr"}, 32'(out_addr), 32'(exp_addr));
        check({tag, "/we"}, 32'(out_we), 32'(we));
        if (req_bank >= 0) begin
            bank_wr  = 1'b1;
            bank_din = 4'(req_bank);
        end
        region_ack = (wait_n == 0) ? exp_req : ~exp_req;
        for (int j = 1; j <= wait_n; j++) begin
            step();
            bank_wr  = 1'b0;
            cpu_req  = drop && (j == 1);
            cpu_addr = 20'h12345;
            check({tag, "/req_hold"}, 32'(region_req), 32'(exp_req));
            check({tag, "/addr_hold"}, 32'(out_addr), 32'(exp_addr));
            check({tag, "/rdy_wait"}, 32'(cpu_ready), 32'd0);
            region_ack = (j == wait_n) ? exp_req : ~exp_req;
        end
        step();  // ack sampled: DONE
        bank_wr    = 1'b0;
        cpu_req    = 1'b0;
        region_ack = '0;
        check({tag, "/req_clr"}, 32'(region_req), 32'd0);
        check({tag, "/rdy_early"}, 32'(cpu_ready), 32'd0);
        step();  // ready cycle
        check({tag, "/rdy"}, 32'(cpu_ready), 32'd1);
        check({tag, "/err"}, 32'(cpu_err), 32'd0);
        check({tag, "/busy_clr"}, 32'(busy), 32'd0);
        step();
        check({tag, "/rdy_once"}, 32'(cpu_ready), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        cpu_we     = 1'b0;
        bank_wr    = 1'b0;
        bank_din   = '0;
        bank_mask  = 4'hF;
        region_ack = '0;
        step();
        step();
        check("rst/req", 32'(region_req), 32'd0);
        check("rst/rdy", 32'(cpu_ready), 32'd0);
        check("rst/err", 32'(cpu_err), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/addr", 32'(out_addr), 32'd0);
        check("rst/we", 32'(out_we), 32'd0);
        reset_n = 1'b1;
        step();

        access(20'h12345, 1'b0, 0, 5'b10000, 20'h12345, "dflt");

        bank_wr  = 1'b1;
        bank_din = 4'h5;
        step();
        bank_wr = 1'b0;
        access(20'h81234, 1'b0, 0, 5'b00001, 20'h51234, "bank_f");
        bank_mask = 4'h0;
        access(20'h81234, 1'b0, 0, 5'b00001, 20'h81234, "bank_0");
        bank_mask = 4'h3;
        access(20'h81234, 1'b1, 0, 5'b00001, 20'h91234, "bank_3");
        bank_mask = 4'hF;

        // Back-to-back accesses across the table and the default region.
        access(20'hA5555, 1'b0, 0, 5'b00010, 20'hA5555, "prio_a");
        access(20'hB1234, 1'b1, 0, 5'b00100, 20'hB1234, "win2");
        access(20'hD0042, 1'b0, 0, 5'b01000, 20'hD0042, "win3");
        access(20'hE0000, 1'b0, 0, 5'b10000, 20'h60000, "dflt_e");
        access(20'hF1234, 1'b1, 0, 5'b10000, 20'h71234, "dflt_f");

        access(20'hD0000, 1'b1, 3, 5'b01000, 20'hD0000, "wait3", -1, -1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("drop/busy", 32'(busy), 32'd0);
            check("drop/req", 32'(region_req), 32'd0);
            step();
        end

        access(20'h8ABCD, 1'b0, 2, 5'b00001, 20'h5ABCD, "bwr_req", -1, 3);
        access(20'h8ABCD, 1'b0, 0, 5'b00001, 20'h3ABCD, "bwr_next");
        access(20'h8ABCD, 1'b0, 0, 5'b00001, 20'h7ABCD, "bwr_strobe", 7);

`ifndef REGION_TIMEOUT_EN
        access(20'h12345, 1'b0, 20, 5'b10000, 20'h12345, "long_wait");
`else
        cpu_req  = 1'b1;
        cpu_addr = 20'hD1111;
        step();
        cpu_req = 1'b0;
        step();  // cycle 2: first REQ cycle
        for (int k = 0; k < 8; k++) begin
            check("to/req_hold", 32'(region_req), 32'b01000);
            step();
        end
        check("to/req_drop", 32'(region_req), 32'd0);
        check("to/rdy_early", 32'(cpu_ready), 32'd0);
        step();
        check("to/rdy", 32'(cpu_ready), 32'd1);
        check("to/err", 32'(cpu_err), 32'd1);
        step();
        check("to/rdy_once", 32'(cpu_ready), 32'd0);
        check("to/err_once", 32'(cpu_err), 32'd0);
`endif

        // Reset while a request is outstanding.
        cpu_req  = 1'b1;
        cpu_addr = 20'hA0001;
        step();
        cpu_req = 1'b0;
        step();
        check("mid/req", 32'(region_req), 32'b00010);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid/req_clr", 32'(region_req), 32'd0);
        check("mid/busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("mid/no_rdy", 32'(cpu_ready), 32'd0);
        end
        access(20'h81234, 1'b0, 0, 5'b00001, 20'h01234, "bank_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_region_decoder.md
# bus_region_decoder

Parametrised, registered successor to the M90 combinational address translator. It decodes a CPU access against a table of up to NUM_REGIONS address windows, with lowest index winning. One window is banked through an internal bank register. The block launches a one-hot request to the selected memory, holds it until that memory acknowledges, and then returns a one-cycle ready pulse to the CPU bus interface. It sits between the V35/V33 bus interface and the ROM/RAM/GA25/palette arbiters.

## Interface
Parameters:
- ADDR_W, 20, CPU address width.
- NUM_REGIONS, 4, number of table windows. Unmatched addresses go to the default region at index NUM_REGIONS.
- REGION_BASE, {20'hD0000,20'hA0000,20'hE0000,20'h80000}, packed NUM_REGIONS×ADDR_W vector. Entry i occupies bits [i*ADDR_W +: ADDR_W].
- REGION_MASK, {4{20'hF0000}}, packed mask per entry. Entry i matches when (A & MASK_i) == (BASE_i & MASK_i).
- BANK_REGION, 0, index of the banked window.
- BANK_W, 4, bank register width. It replaces A[ADDR_W-1 -: BANK_W] under BANK_MASK.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only with the macro.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- cpu_req, in, 1, one-cycle access strobe.
- cpu_addr, in, ADDR_W, access address.
- cpu_we, in, 1, write flag. Latched and forwarded.
- cpu_ready, out, 1, one-cycle completion pulse.
- cpu_err, out, 1, qualifies cpu_ready on a timeout.
- busy, out, 1, high from strobe acceptance until cpu_ready.
- bank_wr, in, 1, bank register write strobe.
- bank_din, in, BANK_W, bank value.
- bank_mask, in, BANK_W, per-bit bank enable from board config.
- region_req, out, NUM_REGIONS+1, one-hot request. Bit NUM_REGIONS is the default (ROM) request.
- region_ack, in, NUM_REGIONS+1, per-region acknowledge.
- out_addr, out, ADDR_W, translated address. Valid while region_req is non-zero.
- out_we, out, 1, latched cpu_we.

## Operation
States are IDLE, DECODE, REQ and DONE. A fifth state, ERR, exists only with the macro.

- **IDLE**
  - cpu_req is accepted only in IDLE. Strobes seen in any other state are dropped.
  - On acceptance the block latches cpu_addr and cpu_we, sets busy and moves to DECODE.
- **DECODE**
  - Match the latched address against the table with lowest-index priority.
  - Banked window: out_addr = {(bank_q & bank_mask) | (A_top & ~bank_mask), A[ADDR_W-BANK_W-1:0]}, where A_top = A[ADDR_W-1 -: BANK_W].
  - Other table windows: out_addr = A.
  - Default region: out_addr = {1'b0, A[ADDR_W-2:0]}.
  - Register the one-hot select and out_addr, then move to REQ.
- **REQ**
  - Hold region_req and out_addr constant.
  - Leave when region_ack[sel] is high. Ack bits of unselected regions are ignored.
  - On ack, clear region_req on the next edge and move to DONE.
- **DONE**
  - Pulse cpu_ready for one cycle, clear busy and return to IDLE.
- **Bank register**
  - bank_q <= bank_din on bank_wr, in any state.
  - Translation samples bank_q in DECODE. A write landing in DECODE or later does not affect the access in flight.
  - bank_wr in the same cycle as an accepted cpu_req is visible to that access.

## Timing
- Reset values:
  - State IDLE.
  - cpu_ready, cpu_err, busy, region_req, out_we and bank_q all 0.
  - out_addr is 0.
- Cycle-level sequence with zero-wait ack:
  - cpu_req high at edge 0.
  - DECODE during cycle 1.
  - region_req high from edge 2.
  - ack sampled high at edge 3.
  - cpu_ready high for cycle 4.
  - Minimum latency from strobe to ready is 4 cycles; each ack wait cycle adds 1.
- Back-to-back: the earliest next accepted cpu_req is the cycle after cpu_ready, i.e. a 5-cycle issue period.
- Reset mid-operation:
  - Return to IDLE on the next edge.
  - region_req drops and no cpu_ready is generated.
  - bank_q is cleared.

## Configuration
- REGION_TIMEOUT_EN defined:
  - An 8–16-bit counter, sized by TIMEOUT_CYCLES, counts cycles spent in REQ.
  - When it reaches TIMEOUT_CYCLES without ack, the block drops region_req and enters ERR.
  - ERR pulses cpu_ready with cpu_err=1 for one cycle, then returns to IDLE.
  - The counter clears on entry to REQ.
- REGION_TIMEOUT_EN undefined:
  - REQ waits indefinitely.
  - cpu_err is tied to 0 and the ERR state and counter are absent.

## Test plan
- **Default params, reset released:** cpu_req at addr 0x12345 → region_req = 5'b10000 and out_addr = 0x12345 on edge 2. Ack at edge 3 → cpu_ready in cycle 4 only.
- **Banked window:** bank_wr with 0x5, bank_mask = 0xF, then a read at 0x81234 → region_req[0] with out_addr = 0x51234. With bank_mask = 0x0 → out_addr = 0x81234.
- **Priority:** set entries 1 and 2 to overlap on 0xA0000 → only region_req[1] asserts.
- **Wait states and drops:** ack delayed 3 cycles → region_req is held stable for those cycles and cpu_ready occurs 3 cycles later than nominal. A second cpu_req issued while busy produces no extra access.
- **Bank write timing:** bank_wr = 0x3 while in REQ → out_addr is unchanged for that access and the next banked access uses 0x3.
- **Timeout and reset:** with REGION_TIMEOUT_EN and TIMEOUT_CYCLES = 8, never ack → region_req drops after 8 REQ cycles and cpu_ready & cpu_err pulse once. Separately, reset_n low during REQ → region_req is 0 on the next edge and no cpu_ready follows.
